// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: shared state, port-id and write-mask constants for the RAM arbiter
package mem_bus_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;
  localparam logic [3:0] WMASK_NONE = 4'b0000;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one synchronous RAM between fetch (I) and load/store (D) ports
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  I_REQ,
  input  logic [ADDR_WIDTH-1:0] I_ADDR,
  output logic [DATA_WIDTH-1:0] I_RDATA,
  output logic                  I_ACK,
  input  logic                  D_REQ,
  input  logic [ADDR_WIDTH-1:0] D_ADDR,
  input  logic [3:0]            D_WMASK,
  input  logic [DATA_WIDTH-1:0] D_WDATA,
  output logic [DATA_WIDTH-1:0] D_RDATA,
  output logic                  D_ACK,
  output logic [ADDR_WIDTH-3:0] M_ADDR,
  output logic                  M_RSTRB,
  output logic [3:0]            M_WMASK,
  output logic [DATA_WIDTH-1:0] M_WDATA,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  output logic [1:0]            GRANT
);
  state_e state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, wr_q, wr_d, pick;
  logic i_ack_q, i_ack_d, d_ack_q, d_ack_d, m_rstrb_q, m_rstrb_d;
  logic [ADDR_WIDTH-3:0] m_addr_q, m_addr_d;
  logic [3:0] m_wmask_q, m_wmask_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d, i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0] grant_q, grant_d;
  logic i_eff, d_eff;
  logic unused_addr_lsbs;

  assign unused_addr_lsbs = ^{I_ADDR[1:0], D_ADDR[1:0]};
  assign i_eff = I_REQ & ~i_ack_q;
  assign d_eff = D_REQ & ~d_ack_q;

  function automatic logic rr_pick(input logic i_req, input logic d_req);
    return (i_req & d_req) ? ~last_q : (i_req ? PORT_I : PORT_D);
  endfunction

  // Register every piece of state and every output; reset drops any transaction in flight
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q   <= ST_IDLE;
      last_q    <= PORT_D;
      owner_q   <= PORT_I;
      wr_q      <= 1'b0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      m_rstrb_q <= 1'b0;
      m_addr_q  <= '0;
      m_wmask_q <= WMASK_NONE;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      grant_q   <= 2'b00;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      m_rstrb_q <= m_rstrb_d;
      m_addr_q  <= m_addr_d;
      m_wmask_q <= m_wmask_d;
      m_wdata_q <= m_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      grant_q   <= grant_d;
    end
  end

  // IDLE grants and latches the request, ISSUE holds the one-cycle strobe, RESP captures data and queues the ACK
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    m_rstrb_d = 1'b0;
    m_addr_d  = m_addr_q;
    m_wmask_d = WMASK_NONE;
    m_wdata_d = m_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    grant_d   = grant_q;
    pick      = rr_pick(i_eff, d_eff);
    case (state_q)
      ST_IDLE: if (i_eff | d_eff) begin
        owner_d   = pick;
        last_d    = pick;
        wr_d      = (pick == PORT_D) && (D_WMASK != WMASK_NONE);
        m_addr_d  = (pick == PORT_D) ? D_ADDR[ADDR_WIDTH-1:2] : I_ADDR[ADDR_WIDTH-1:2];
        m_rstrb_d = ~wr_d;
        m_wmask_d = wr_d ? D_WMASK : WMASK_NONE;
        m_wdata_d = (pick == PORT_D) ? D_WDATA : '0;
        grant_d   = (pick == PORT_D) ? 2'b10 : 2'b01;
        state_d   = ST_ISSUE;
      end
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        i_rdata_d = (!wr_q && owner_q == PORT_I) ? M_RDATA : i_rdata_q;
        d_rdata_d = (!wr_q && owner_q == PORT_D) ? M_RDATA : d_rdata_q;
        i_ack_d   = owner_q == PORT_I;
        d_ack_d   = owner_q == PORT_D;
        grant_d   = 2'b00;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign I_RDATA = i_rdata_q;
  assign I_ACK   = i_ack_q;
  assign D_RDATA = d_rdata_q;
  assign D_ACK   = d_ack_q;
  assign M_ADDR  = m_addr_q;
  assign M_RSTRB = m_rstrb_q;
  assign M_WMASK = m_wmask_q;
  assign M_WDATA = m_wdata_q;
  assign GRANT   = grant_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard-driven bench for mem_bus_arbiter with a behavioural synchronous RAM
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;
  typedef struct packed {logic port; logic [31:0] data;} exp_t;

  logic CLK = 1'b0, RESETN = 1'b0;
  logic I_REQ = 1'b0, D_REQ = 1'b0, I_ACK, D_ACK, M_RSTRB;
  logic [31:0] I_ADDR = '0, D_ADDR = '0, D_WDATA = '0;
  logic [3:0] D_WMASK = '0, M_WMASK;
  logic [31:0] I_RDATA, D_RDATA, M_WDATA, M_RDATA = '0;
  logic [29:0] M_ADDR;
  logic [1:0] GRANT;
  logic [31:0] mem [0:255];
  logic [31:0] exp_d_rdata;
  exp_t q[$];
  int tests = 0, failed = 0;

  mem_bus_arbiter dut (
    .CLK(CLK), .RESETN(RESETN),
    .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_RDATA(I_RDATA), .I_ACK(I_ACK),
    .D_REQ(D_REQ), .D_ADDR(D_ADDR), .D_WMASK(D_WMASK), .D_WDATA(D_WDATA),
    .D_RDATA(D_RDATA), .D_ACK(D_ACK),
    .M_ADDR(M_ADDR), .M_RSTRB(M_RSTRB), .M_WMASK(M_WMASK), .M_WDATA(M_WDATA),
    .M_RDATA(M_RDATA), .GRANT(GRANT)
  );

  always #5 CLK = ~CLK;

  // Single-port RAM: read data appears the cycle after the strobe, writes honour byte enables
  always @(posedge CLK) begin
    if (M_RSTRB) M_RDATA <= mem[M_ADDR[7:0]];
    for (int b = 0; b < 4; b++)
      if (M_WMASK[b]) mem[M_ADDR[7:0]][8*b +: 8] <= M_WDATA[8*b +: 8];
  end

  task automatic test_reset;
    RESETN = 1'b0; I_REQ = 1'b0; D_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    tests++;
    if ({I_RDATA, I_ACK, D_RDATA, D_ACK, M_ADDR, M_RSTRB, M_WMASK, M_WDATA, GRANT} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: I_ACK=%b D_ACK=%b M_RSTRB=%b M_WMASK=%b GRANT=%b M_ADDR=%h, expected all zero",
               I_ACK, D_ACK, M_RSTRB, M_WMASK, GRANT, M_ADDR);
    end
    exp_d_rdata = '0;
    RESETN = 1'b1;
  endtask

  task automatic test_idle;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      tests++;
      if ({M_RSTRB, M_WMASK, GRANT, I_ACK, D_ACK} !== 9'b0) begin
        failed++;
        $display("FAIL idle_quiet: cycle %0d M_RSTRB=%b M_WMASK=%b GRANT=%b I_ACK=%b D_ACK=%b, expected all zero",
                 c, M_RSTRB, M_WMASK, GRANT, I_ACK, D_ACK);
      end
    end
  endtask

  task automatic test_i_read;
    exp_t e;
    mem[4] = 32'h0000_0513;
    I_ADDR = 32'h0000_0010; I_REQ = 1'b1;
    q.push_back('{PORT_I, 32'h0000_0513});
    @(negedge CLK);
    tests++;
    if (M_ADDR !== 30'd4 || M_RSTRB !== 1'b1 || M_WMASK !== 4'b0 || GRANT !== 2'b01) begin
      failed++;
      $display("FAIL i_issue: M_ADDR=%h M_RSTRB=%b M_WMASK=%b GRANT=%b, expected 4 1 0000 01",
               M_ADDR, M_RSTRB, M_WMASK, GRANT);
    end
    @(negedge CLK);
    tests++;
    if (M_RSTRB !== 1'b0 || I_ACK !== 1'b0 || GRANT !== 2'b01) begin
      failed++;
      $display("FAIL i_resp: M_RSTRB=%b I_ACK=%b GRANT=%b, expected 0 0 01", M_RSTRB, I_ACK, GRANT);
    end
    @(negedge CLK);
    e = q.pop_front();
    tests++;
    if (I_ACK !== 1'b1 || I_RDATA !== e.data || GRANT !== 2'b00) begin
      failed++;
      $display("FAIL i_ack: I_ACK=%b I_RDATA=%h GRANT=%b, expected 1 %h 00", I_ACK, I_RDATA, GRANT, e.data);
    end
    I_REQ = 1'b0;
    @(negedge CLK);
    tests++;
    if (I_ACK !== 1'b0) begin
      failed++;
      $display("FAIL i_ack_pulse: I_ACK=%b, expected 0", I_ACK);
    end
  endtask

  task automatic test_d_write;
    exp_t e;
    mem[8] = 32'h1122_3344;
    D_ADDR = 32'h0000_0020; D_WMASK = 4'b0011; D_WDATA = 32'hDEAD_BEEF; D_REQ = 1'b1;
    q.push_back('{PORT_D, exp_d_rdata});
    @(negedge CLK);
    tests++;
    if (M_WMASK !== 4'b0011 || M_ADDR !== 30'd8 || M_RSTRB !== 1'b0 || M_WDATA !== 32'hDEAD_BEEF || GRANT !== 2'b10) begin
      failed++;
      $display("FAIL d_write_issue: M_WMASK=%b M_ADDR=%h M_RSTRB=%b M_WDATA=%h GRANT=%b, expected 0011 8 0 deadbeef 10",
               M_WMASK, M_ADDR, M_RSTRB, M_WDATA, GRANT);
    end
    @(negedge CLK);
    tests++;
    if (M_WMASK !== 4'b0 || M_RSTRB !== 1'b0) begin
      failed++;
      $display("FAIL d_write_single: M_WMASK=%b M_RSTRB=%b, expected 0000 0", M_WMASK, M_RSTRB);
    end
    @(negedge CLK);
    e = q.pop_front();
    tests++;
    if (D_ACK !== 1'b1 || D_RDATA !== e.data) begin
      failed++;
      $display("FAIL d_write_ack: D_ACK=%b D_RDATA=%h, expected 1 %h", D_ACK, D_RDATA, e.data);
    end
    D_REQ = 1'b0; D_WMASK = 4'b0;
    @(negedge CLK);
    tests++;
    if (D_ACK !== 1'b0 || mem[8] !== 32'h1122_BEEF) begin
      failed++;
      $display("FAIL d_write_mem: D_ACK=%b mem[8]=%h, expected 0 1122beef", D_ACK, mem[8]);
    end
  endtask

  task automatic test_conflict;
    exp_t e;
    int n = 0;
    logic chk = 1'b1;
    logic [1:0] exp_g = 2'b01;
    mem[16] = 32'hA0A0_0001; mem[17] = 32'hB0B0_0002;
    I_ADDR = 32'h40; D_ADDR = 32'h44; D_WMASK = 4'b0;
    for (int k = 0; k < 4; k++)
      q.push_back(k[0] ? '{PORT_D, 32'hB0B0_0002} : '{PORT_I, 32'hA0A0_0001});
    I_REQ = 1'b1; D_REQ = 1'b1;
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge CLK);
      if (chk) begin
        tests++;
        if (GRANT !== exp_g) begin
          failed++;
          $display("FAIL conflict_grant: after ack %0d GRANT=%b, expected %b", n, GRANT, exp_g);
        end
        chk = 1'b0;
      end
      if (I_ACK === 1'b1 || D_ACK === 1'b1) begin
        e = q.pop_front();
        tests++;
        if ({D_ACK, I_ACK} !== (e.port ? 2'b10 : 2'b01) || (e.port ? D_RDATA : I_RDATA) !== e.data) begin
          failed++;
          $display("FAIL conflict_ack: ack %0d D_ACK=%b I_ACK=%b I_RDATA=%h D_RDATA=%h, expected port %0d data %h",
                   n, D_ACK, I_ACK, I_RDATA, D_RDATA, e.port, e.data);
        end
        n++;
        exp_g = e.port ? 2'b01 : 2'b10;
        chk = n < 4;
        if (n == 4) begin I_REQ = 1'b0; D_REQ = 1'b0; end
      end
    end
    if (n < 4) begin
      tests++; failed++;
      $display("FAIL conflict_timeout: %0d acks seen, expected 4", n);
      I_REQ = 1'b0; D_REQ = 1'b0;
    end
    q.delete();
    exp_d_rdata = 32'hB0B0_0002;
    repeat (4) @(negedge CLK);
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int n = 0, last = 0;
    logic nochk = 1'b0;
    for (int k = 0; k < 4; k++) mem[20 + k] = 32'hC000_0000 + k;
    D_WMASK = 4'b0; D_ADDR = 32'h50; D_REQ = 1'b1;
    q.push_back('{PORT_D, 32'hC000_0000});
    for (int c = 0; c < 80 && n < 4; c++) begin
      @(negedge CLK);
      if (nochk) begin
        tests++;
        if (GRANT !== 2'b00) begin
          failed++;
          $display("FAIL b2b_no_dup_grant: GRANT=%b in cycle after ack, expected 00", GRANT);
        end
        nochk = 1'b0;
      end
      if (D_ACK === 1'b1) begin
        e = q.pop_front();
        tests++;
        if (D_RDATA !== e.data) begin
          failed++;
          $display("FAIL b2b_data: read %0d D_RDATA=%h, expected %h", n, D_RDATA, e.data);
        end
        if (n > 0) begin
          tests++;
          if (c - last != 4) begin
            failed++;
            $display("FAIL b2b_interval: %0d cycles between acks, expected 4", c - last);
          end
        end
        last = c;
        n++;
        if (n < 4) begin
          D_ADDR = 32'h50 + 32'(4 * n);
          q.push_back('{PORT_D, 32'hC000_0000 + 32'(n)});
          nochk = 1'b1;
        end else D_REQ = 1'b0;
      end
    end
    if (n < 4) begin
      tests++; failed++;
      $display("FAIL b2b_timeout: %0d acks seen, expected 4", n);
      D_REQ = 1'b0;
    end
    q.delete();
    exp_d_rdata = 32'hC000_0003;
    repeat (2) @(negedge CLK);
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int n = 0;
    I_ADDR = 32'h10; I_REQ = 1'b1;
    q.push_back('{PORT_I, 32'h0000_0513});
    repeat (2) @(negedge CLK);
    tests++;
    if (GRANT !== 2'b01 || M_RSTRB !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_resp: GRANT=%b M_RSTRB=%b, expected 01 0", GRANT, M_RSTRB);
    end
    RESETN = 1'b0;
    @(negedge CLK);
    tests++;
    if ({I_RDATA, I_ACK, D_RDATA, D_ACK, M_ADDR, M_RSTRB, M_WMASK, M_WDATA, GRANT} !== '0) begin
      failed++;
      $display("FAIL rst_mid_clear: I_ACK=%b I_RDATA=%h D_RDATA=%h GRANT=%b M_ADDR=%h, expected all zero",
               I_ACK, I_RDATA, D_RDATA, GRANT, M_ADDR);
    end
    q.delete();
    exp_d_rdata = '0;
    RESETN = 1'b1; I_REQ = 1'b0;
    @(negedge CLK);
    tests++;
    if (I_ACK !== 1'b0 || GRANT !== 2'b00) begin
      failed++;
      $display("FAIL rst_mid_dropped: I_ACK=%b GRANT=%b, expected 0 00", I_ACK, GRANT);
    end
    mem[24] = 32'h600D_F00D;
    D_ADDR = 32'h60; D_WMASK = 4'b0; D_REQ = 1'b1;
    q.push_back('{PORT_D, 32'h600D_F00D});
    for (int c = 0; c < 10 && n == 0; c++) begin
      @(negedge CLK);
      if (D_ACK === 1'b1) begin
        e = q.pop_front();
        n++;
        D_REQ = 1'b0;
        tests++;
        if (D_RDATA !== e.data || I_RDATA !== 32'h0) begin
          failed++;
          $display("FAIL rst_mid_after: D_RDATA=%h I_RDATA=%h, expected %h 00000000", D_RDATA, I_RDATA, e.data);
        end
      end
    end
    if (n == 0) begin
      tests++; failed++;
      $display("FAIL rst_mid_timeout: no D_ACK after reset release");
      D_REQ = 1'b0;
    end
    q.delete();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) mem[k] = 32'h0;
    test_reset();
    test_idle();
    test_i_read();
    test_d_write();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
